// File: rtl/hilo_unit_pkg.sv
// Shared MIPS HI/LO types: operand words, HI/LO op codes and divider step count.
// Also holds the small sign helpers used by the HI/LO unit.
package hilo_unit_pkg;

   typedef logic [31:0] word_t;
   typedef logic [63:0] double_word_t;

   typedef enum logic [3:0] {
      HOP_NONE  = 4'd0,
      HOP_MULT  = 4'd1,
      HOP_MULTU = 4'd2,
      HOP_MTHI  = 4'd3,
      HOP_MTLO  = 4'd4,
      HOP_MADD  = 4'd5,
      HOP_MADDU = 4'd6,
      HOP_MSUB  = 4'd7,
      HOP_MSUBU = 4'd8,
      HOP_DIV   = 4'd9,
      HOP_DIVU  = 4'd10
   } hilo_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MACC = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } hilo_state_t;

   localparam int DIV_STEPS = 32;

   // Magnitude of a word; unsigned operands pass through untouched.
   function automatic word_t abs_word(input word_t v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

   function automatic word_t neg_if(input word_t v, input logic en);
      return en ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_radix2.sv
// Unsigned restoring radix-2 divider: one quotient bit per cycle, DIV_STEPS cycles.
// done is high during the cycle that performs the final step.
import hilo_unit_pkg::*;

module div_radix2 (
   input  logic  clk,
   input  logic  rst,
   input  logic  start,
   input  word_t dividend,
   input  word_t divisor,
   output word_t quotient,
   output word_t remainder,
   output logic  done
);

   localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

   logic [4:0]  count_r;
   logic        active_r;
   word_t       rem_r;
   word_t       quo_r;
   word_t       dsr_r;
   logic [32:0] shifted_s;
   logic [32:0] diff_s;

   // Trial subtraction; bit 32 set means the shifted remainder is below the divisor.
   always_comb begin
      shifted_s = {rem_r, quo_r[31]};
      diff_s    = shifted_s - {1'b0, dsr_r};
   end

   // Operand load on start, then one shift/subtract step per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r  <= 5'd0;
         active_r <= 1'b0;
         rem_r    <= 32'd0;
         quo_r    <= 32'd0;
         dsr_r    <= 32'd0;
      end else if (start) begin
         count_r  <= 5'd0;
         active_r <= 1'b1;
         rem_r    <= 32'd0;
         quo_r    <= dividend;
         dsr_r    <= divisor;
      end else if (active_r) begin
         if (!diff_s[32]) begin
            rem_r <= diff_s[31:0];
            quo_r <= {quo_r[30:0], 1'b1};
         end else begin
            rem_r <= shifted_s[31:0];
            quo_r <= {quo_r[30:0], 1'b0};
         end
         count_r <= count_r + 5'd1;
         if (count_r == LAST_STEP) begin
            active_r <= 1'b0;
         end
      end
   end

   assign done      = active_r && (count_r == LAST_STEP);
   assign quotient  = quo_r;
   assign remainder = rem_r;

endmodule

// File: rtl/hilo_unit.sv
// MIPS HI/LO register unit: MULT/MT*/MADD/MSUB/DIV with Execute-stage stall control.
// Multiply products come from the ALU; division runs on the iterative div_radix2.
import hilo_unit_pkg::*;

module hilo_unit (
   input  logic         clk,
   input  logic         rst,
   input  logic         op_valid,
   input  hilo_op_t     op,
   input  word_t        a,
   input  word_t        b,
   input  double_word_t prod,
   input  logic         flush,
   output double_word_t hilo,
   output logic         stall_reqE,
   output logic         busy
);

   hilo_state_t  state_r;
   double_word_t hilo_r;
   double_word_t acc_tmp_r;
   logic         msub_r;
   logic         quo_neg_r;
   logic         rem_neg_r;

   logic  is_macc_s;
   logic  is_div_s;
   logic  div_signed_s;
   logic  accept_s;
   logic  div_start_s;
   logic  div_done_s;
   word_t div_quo_s;
   word_t div_rem_s;

   // Decode of the op presented to an idle unit.
   always_comb begin
      is_macc_s    = (op == HOP_MADD) || (op == HOP_MADDU) ||
                     (op == HOP_MSUB) || (op == HOP_MSUBU);
      is_div_s     = ((op == HOP_DIV) || (op == HOP_DIVU)) && (b != 32'd0);
      div_signed_s = (op == HOP_DIV);
      accept_s     = (state_r == ST_IDLE) && op_valid && !flush && !rst;
      div_start_s  = accept_s && is_div_s;
   end

   // Stall the Execute stage while a multi-cycle op is being accepted or divided.
   always_comb begin
      if (rst || flush) begin
         stall_reqE = 1'b0;
      end else if (state_r == ST_DIV) begin
         stall_reqE = 1'b1;
      end else if (accept_s && (is_macc_s || is_div_s)) begin
         stall_reqE = 1'b1;
      end else begin
         stall_reqE = 1'b0;
      end
   end

   div_radix2 u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start_s),
      .dividend  (abs_word(a, div_signed_s)),
      .divisor   (abs_word(b, div_signed_s)),
      .quotient  (div_quo_s),
      .remainder (div_rem_s),
      .done      (div_done_s)
   );

   // Control FSM and HI/LO register updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         hilo_r    <= 64'd0;
         acc_tmp_r <= 64'd0;
         msub_r    <= 1'b0;
         quo_neg_r <= 1'b0;
         rem_neg_r <= 1'b0;
      end else if (flush) begin
         state_r <= ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (op_valid) begin
                  case (op)
                     HOP_MULT, HOP_MULTU: hilo_r <= prod;
                     HOP_MTHI:            hilo_r[63:32] <= a;
                     HOP_MTLO:            hilo_r[31:0]  <= a;
                     HOP_MADD, HOP_MADDU, HOP_MSUB, HOP_MSUBU: begin
                        acc_tmp_r <= prod;
                        msub_r    <= (op == HOP_MSUB) || (op == HOP_MSUBU);
                        state_r   <= ST_MACC;
                     end
                     HOP_DIV, HOP_DIVU: begin
                        if (b != 32'd0) begin
                           quo_neg_r <= div_signed_s && (a[31] ^ b[31]);
                           rem_neg_r <= div_signed_s && a[31];
                           state_r   <= ST_DIV;
                        end
                     end
                     default: state_r <= ST_IDLE;
                  endcase
               end
            end
            ST_MACC: begin
               hilo_r  <= msub_r ? (hilo_r - acc_tmp_r) : (hilo_r + acc_tmp_r);
               state_r <= ST_IDLE;
            end
            ST_DIV: begin
               if (div_done_s) begin
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               hilo_r  <= {neg_if(div_rem_s, rem_neg_r), neg_if(div_quo_s, quo_neg_r)};
               state_r <= ST_IDLE;
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign hilo = hilo_r;
   assign busy = (state_r != ST_IDLE) && !rst;

endmodule
